// File: rtl/alu_serial_pkg.sv
// Shared definitions for the digit-serial ALU: opcode encoding, FSM states,
// flag bundle and a small opcode classification helper.
package alu_serial_pkg;

  // Digit width processed per clock by the serial datapath.
  localparam int DIGIT_W = 4;

  // Opcode encoding is identical to the legacy combinational ALU so the
  // existing instruction decoder can drive this block unchanged.
  typedef enum logic [2:0] {
    ALU_AI  = 3'd0,
    ALU_BI  = 3'd1,
    ALU_ADC = 3'd2,
    ALU_ROL = 3'd3,
    ALU_ROR = 3'd4,
    ALU_ORA = 3'd5,
    ALU_EOR = 3'd6,
    ALU_AND = 3'd7
  } alu_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Flag bundle presented alongside the result.
  typedef struct packed {
    logic c;
    logic n;
    logic z;
    logic v;
  } alu_flags_t;

  // Ops that need no digit loop: the result is formed whole at accept time.
  function automatic logic is_single_cycle(input alu_op_e op_i);
    return op_i inside {ALU_AI, ALU_BI, ALU_ROL, ALU_ROR};
  endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational 4-bit ALU slice: binary/BCD add and bitwise logic for one digit.
// Also exposes the carry into bit 3 and the uncorrected carry out of bit 3 so
// the caller can form signed overflow from the raw binary sum.
module alu_digit
  import alu_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  alu_op_e    op,
  input  logic       dec,
  input  logic       sub,
  output logic [3:0] result,
  output logic       cout,
  output logic       c3,
  output logic       c4
);

  logic [4:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};

  // Carry into bit 3 recovered from the sum bit and its two addend bits.
  assign c3 = a[3] ^ b[3] ^ w_sum[3];
  assign c4 = w_sum[4];

  // Select the digit result; decimal correction applies to ADC only, all
  // other ops keep the plain binary carry so the chain matches legacy flags.
  always_comb begin
    result = w_sum[3:0];
    cout   = w_sum[4];
    case (op)
      ALU_ORA: result = a | b;
      ALU_EOR: result = a ^ b;
      ALU_AND: result = a & b;
      ALU_ADC: begin
        if (dec) begin
          if (!sub) begin
            // BCD add: any sum past 9 wraps by adding 6 and carries.
            if (w_sum > 5'd9) begin
              result = w_sum[3:0] + 4'd6;
              cout   = 1'b1;
            end else begin
              cout   = 1'b0;
            end
          end else begin
            // BCD subtract (b is the ones' complement): no binary carry means
            // a borrow, so fold the digit back into 0..9 by adding 10.
            if (!w_sum[4]) begin
              result = w_sum[3:0] + 4'd10;
              cout   = 1'b0;
            end else begin
              cout   = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU. Accepts a request over a valid/ready handshake, runs
// arithmetic/logic ops one 4-bit digit per clock (LSB first) through a single
// alu_digit slice, and holds the result and flags until the consumer takes it.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] mi,
  input  logic             ci,
  input  logic             mem_bi,
  input  logic             inv_bi,
  input  logic             dec,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  // Reject widths the digit loop cannot cover exactly.
  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("alu_serial: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             r_alive;

  // Captured request and digit engine state.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_cy;
  logic             r_dec;
  logic             r_sub;
  alu_op_e          r_op;
  logic [KW-1:0]    r_k;

  // Presented result and flags.
  logic [WIDTH-1:0] r_out;
  alu_flags_t       r_flags;

  logic             w_accept;
  logic             w_last;
  alu_op_e          w_op;
  logic [WIDTH-1:0] w_bi;
  logic [WIDTH:0]   w_bin;
  logic [WIDTH-1:0] w_short_res;
  logic             w_short_c;
  logic             w_short_v;
  logic [3:0]       w_d_res;
  logic             w_d_cout;
  logic             w_d_c3;
  logic             w_d_c4;
  logic [WIDTH-1:0] w_acc_next;

  assign w_op     = alu_op_e'(op);
  assign w_bi     = (mi & {WIDTH{mem_bi}}) ^ {WIDTH{inv_bi}};
  assign w_bin    = {1'b0, ai} + {1'b0, w_bi} + {{WIDTH{1'b0}}, ci};
  assign w_accept = in_ready && in_valid;
  assign w_last   = (r_k == K_LAST);

  // Whole-word results for the ops that skip the digit loop. Carry and
  // overflow still come from the full binary sum so flags stay legacy-compatible.
  always_comb begin
    w_short_res = ai;
    w_short_c   = w_bin[WIDTH];
    w_short_v   = ai[WIDTH-1] ^ w_bi[WIDTH-1] ^ w_bin[WIDTH-1] ^ w_bin[WIDTH];
    case (w_op)
      ALU_BI:  w_short_res = w_bi;
      ALU_ROL: begin
        w_short_res = {ai[WIDTH-2:0], ci};
        w_short_c   = ai[WIDTH-1];
      end
      ALU_ROR: begin
        w_short_res = {ci, ai[WIDTH-1:1]};
        w_short_c   = ai[0];
      end
      default: ;
    endcase
  end

  // The single digit slice always works on the low digit of the shifting operands.
  alu_digit u_digit (
    .a      (r_a[3:0]),
    .b      (r_b[3:0]),
    .cin    (r_cy),
    .op     (r_op),
    .dec    (r_dec),
    .sub    (r_sub),
    .result (w_d_res),
    .cout   (w_d_cout),
    .c3     (w_d_c3),
    .c4     (w_d_c4)
  );

  // New digits enter at the top; after DIGITS shifts digit 0 sits at bit 0.
  assign w_acc_next = {w_d_res, r_acc[WIDTH-1:4]};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = is_single_cycle(w_op) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs; in_ready waits for the first edge after reset release.
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && r_alive;
    out_valid = (r_state == ST_DONE);
  end

  // Marks that at least one clock edge has passed since reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
    end
  end

  // Operand capture and per-digit shift/accumulate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cy  <= 1'b0;
      r_dec <= 1'b0;
      r_sub <= 1'b0;
      r_op  <= ALU_AI;
      r_k   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a   <= ai;
            r_b   <= w_bi;
            r_cy  <= ci;
            r_dec <= dec;
            r_sub <= inv_bi;
            r_op  <= w_op;
            r_k   <= '0;
            r_acc <= '0;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> DIGIT_W;
          r_b   <= r_b >> DIGIT_W;
          r_cy  <= w_d_cout;
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result and flag registers: loaded only with a complete result, so a
  // partially computed word is never visible on the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept && is_single_cycle(w_op)) begin
        r_out     <= w_short_res;
        r_flags.c <= w_short_c;
        r_flags.n <= w_short_res[WIDTH-1];
        r_flags.z <= ~|w_short_res;
        r_flags.v <= w_short_v;
      end else if (r_state == ST_RUN && w_last) begin
        r_out     <= w_acc_next;
        r_flags.c <= w_d_cout;
        r_flags.n <= w_acc_next[WIDTH-1];
        r_flags.z <= ~|w_acc_next;
        // Overflow from the raw binary top digit, independent of BCD correction.
        r_flags.v <= w_d_c3 ^ w_d_c4;
      end
    end
  end

  assign out = r_out;
  assign c   = r_flags.c;
  assign n   = r_flags.n;
  assign z   = r_flags.z;
  assign v   = r_flags.v;

endmodule
